// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
// Holds the access FSM state encoding, the default strobe hold time and
// a helper that maps an FSM state to the memory strobe pattern.
package lc3_pkg;

    // Memory access FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Default number of cycles the memory strobes are held per access
    localparam int MEM_WAIT_DEFAULT = 2;

    // Memory strobe bundle, ordered {ce, oe, we}
    typedef struct packed {
        logic ce;
        logic oe;
        logic we;
    } mem_strobe_t;

    // Strobe pattern presented while the FSM sits in state st.
    // Only ACCESS drives the memory; a write raises we, a read raises oe.
    function automatic mem_strobe_t strobes_for(input mem_state_t st, input logic wr);
        mem_strobe_t s;
        case (st)
            ACCESS:  s = '{ce: 1'b1, oe: ~wr, we: wr};
            IDLE:    s = '{ce: 1'b0, oe: 1'b0, we: 1'b0};
            DONE:    s = '{ce: 1'b0, oe: 1'b0, we: 1'b0};
            default: s = '{ce: 1'b0, oe: 1'b0, we: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg16.sv
// 16-bit register with synchronous active-high reset and load enable.
// Used for both MAR and MDR; no arithmetic, it only holds or loads.
module reg16 (
    input  logic        clk,
    input  logic        srst,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Reset clears the register, otherwise load d when enabled, else hold
    always_ff @(posedge clk) begin
        if (srst) begin
            q <= 16'h0000;
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller.
// Owns MAR and MDR and sequences a single memory read or write: the
// strobes are held for WAIT_CYCLES cycles, then R pulses for one cycle.
// CPU-side loads of MAR/MDR are only accepted while idle so the address
// and data stay stable for the whole access.
module mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] BUS,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        start,
    input  logic        we,
    input  logic [15:0] mem_rdata,
    output logic [15:0] MAR_Out,
    output logic [15:0] MDR_Out,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_ce,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        R,
    output logic        busy
);

    // Counter start value: cnt counts down to 0 over WAIT_CYCLES ACCESS cycles
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    mem_state_t  state_r;
    logic [3:0]  cnt_r;
    logic        we_lat_r;

    logic        mar_ld_s;
    logic        mdr_ld_s;
    logic [15:0] mdr_d_s;
    logic        capture_s;

    // Last ACCESS cycle of a read: memory data is valid and goes into MDR
    assign capture_s = (state_r == ACCESS) && (cnt_r == 4'd0) && !we_lat_r;

    // MAR only accepts BUS loads while idle
    assign mar_ld_s = (state_r == IDLE) && LD_MAR;

    // MDR input mux: BUS while idle, memory read data at the end of a read
    always_comb begin
        mdr_ld_s = 1'b0;
        mdr_d_s  = BUS;
        if (state_r == IDLE) begin
            mdr_ld_s = LD_MDR;
            mdr_d_s  = BUS;
        end else if (capture_s) begin
            mdr_ld_s = 1'b1;
            mdr_d_s  = mem_rdata;
        end else begin
            mdr_ld_s = 1'b0;
            mdr_d_s  = BUS;
        end
    end

    reg16 u_mar (
        .clk  (Clk),
        .srst (Reset),
        .ld   (mar_ld_s),
        .d    (BUS),
        .q    (MAR_Out)
    );

    reg16 u_mdr (
        .clk  (Clk),
        .srst (Reset),
        .ld   (mdr_ld_s),
        .d    (mdr_d_s),
        .q    (MDR_Out)
    );

    // The memory always sees the live MAR/MDR contents
    assign mem_addr  = MAR_Out;
    assign mem_wdata = MDR_Out;

    // Access FSM; strobes, R and busy are registered alongside the state
    // so they change on the same edge as the state they describe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r                   <= IDLE;
            cnt_r                     <= 4'd0;
            we_lat_r                  <= 1'b0;
            {mem_ce, mem_oe, mem_we}  <= strobes_for(IDLE, 1'b0);
            R                         <= 1'b0;
            busy                      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r                  <= ACCESS;
                        we_lat_r                 <= we;
                        cnt_r                    <= CNT_INIT;
                        {mem_ce, mem_oe, mem_we} <= strobes_for(ACCESS, we);
                        R                        <= 1'b0;
                        busy                     <= 1'b1;
                    end else begin
                        state_r                  <= IDLE;
                        we_lat_r                 <= we_lat_r;
                        cnt_r                    <= cnt_r;
                        {mem_ce, mem_oe, mem_we} <= strobes_for(IDLE, 1'b0);
                        R                        <= 1'b0;
                        busy                     <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        state_r                  <= ACCESS;
                        cnt_r                    <= cnt_r - 4'd1;
                        {mem_ce, mem_oe, mem_we} <= strobes_for(ACCESS, we_lat_r);
                        R                        <= 1'b0;
                        busy                     <= 1'b1;
                    end else begin
                        // cnt stays at 0 here; it never wraps below zero
                        state_r                  <= DONE;
                        cnt_r                    <= 4'd0;
                        {mem_ce, mem_oe, mem_we} <= strobes_for(DONE, we_lat_r);
                        R                        <= 1'b1;
                        busy                     <= 1'b1;
                    end
                    we_lat_r <= we_lat_r;
                end
                DONE: begin
                    state_r                  <= IDLE;
                    cnt_r                    <= cnt_r;
                    we_lat_r                 <= we_lat_r;
                    {mem_ce, mem_oe, mem_we} <= strobes_for(IDLE, 1'b0);
                    R                        <= 1'b0;
                    busy                     <= 1'b0;
                end
                default: begin
                    state_r                  <= IDLE;
                    cnt_r                    <= 4'd0;
                    we_lat_r                 <= 1'b0;
                    {mem_ce, mem_oe, mem_we} <= strobes_for(IDLE, 1'b0);
                    R                        <= 1'b0;
                    busy                     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance with the default
// wait time and one with WAIT_CYCLES=1. Every started access pushes its
// expected MDR, address and R cycle; monitors pop on each R pulse.
module tb_mem_access_ctrl;

    typedef struct {
        logic [15:0] mdr;
        logic [15:0] addr;
        int          cyc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] BUS = 16'h0000;
    logic [15:0] mem_rdata = 16'h0000;
    logic        ld_mar0 = 1'b0, ld_mdr0 = 1'b0, start0 = 1'b0, we0 = 1'b0;
    logic        ld_mar1 = 1'b0, ld_mdr1 = 1'b0, start1 = 1'b0, we1 = 1'b0;

    logic [15:0] mar0, mdr0, addr0, wdata0;
    logic        ce0, oe0, wen0, r0, busy0;
    logic [15:0] mar1, mdr1, addr1, wdata1;
    logic        ce1, oe1, wen1, r1, busy1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(ld_mar0), .LD_MDR(ld_mdr0),
        .start(start0), .we(we0), .mem_rdata(mem_rdata),
        .MAR_Out(mar0), .MDR_Out(mdr0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_ce(ce0), .mem_oe(oe0), .mem_we(wen0), .R(r0), .busy(busy0)
    );

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(ld_mar1), .LD_MDR(ld_mdr1),
        .start(start1), .we(we1), .mem_rdata(mem_rdata),
        .MAR_Out(mar1), .MDR_Out(mdr1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_ce(ce1), .mem_oe(oe1), .mem_we(wen1), .R(r1), .busy(busy1)
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    // Edge counter used to time R pulses
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Monitor for the default-wait instance: every R pulse must match the next expectation
    always @(negedge Clk) begin
        if (r0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut0_unexpected_R actual R=1 required R=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check16("dut0_R_mdr", mdr0, e.mdr);
                check16("dut0_R_addr", mar0, e.addr);
                checki("dut0_R_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor for the single-wait instance
    always @(negedge Clk) begin
        if (r1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut1_unexpected_R actual R=1 required R=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check16("dut1_R_mdr", mdr1, e.mdr);
                check16("dut1_R_addr", mar1, e.addr);
                checki("dut1_R_cycle", cyc, e.cyc);
            end
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        // Reset then idle
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check16("rst_mar", mar0, 16'h0000);
        check16("rst_mdr", mdr0, 16'h0000);
        check1("rst_busy", busy0, 1'b0);
        check1("rst_R", r0, 1'b0);
        check1("rst_ce", ce0, 1'b0);
        check1("rst_oe", oe0, 1'b0);
        check1("rst_we", wen0, 1'b0);
        check1("rst_busy1", busy1, 1'b0);

        // Read from 0x3000 returning 0xBEEF
        BUS = 16'h3000; ld_mar0 = 1'b1;
        tick();
        ld_mar0 = 1'b0;
        check16("rd_mar_load", mar0, 16'h3000);
        start0 = 1'b1; we0 = 1'b0; mem_rdata = 16'hBEEF;
        q0.push_back('{mdr: 16'hBEEF, addr: 16'h3000, cyc: cyc + 3});
        tick();
        start0 = 1'b0;
        check1("rd_a1_ce", ce0, 1'b1);
        check1("rd_a1_oe", oe0, 1'b1);
        check1("rd_a1_we", wen0, 1'b0);
        check1("rd_a1_busy", busy0, 1'b1);
        check16("rd_a1_addr", addr0, 16'h3000);
        // MAR load attempt while busy
        BUS = 16'hFFFF; ld_mar0 = 1'b1;
        tick();
        check1("rd_a2_ce", ce0, 1'b1);
        check1("rd_a2_oe", oe0, 1'b1);
        check16("busy_ld_mar_a2", mar0, 16'h3000);
        tick();
        // Now in DONE: start must be ignored
        check1("rd_done_ce", ce0, 1'b0);
        check16("busy_ld_mar_done", mar0, 16'h3000);
        ld_mar0 = 1'b0; start0 = 1'b1; we0 = 1'b1;
        tick();
        start0 = 1'b0; we0 = 1'b0;
        check1("done_start_busy", busy0, 1'b0);
        check1("done_start_ce", ce0, 1'b0);
        tick();
        check1("done_start_idle", busy0, 1'b0);
        check16("rd_mdr_hold", mdr0, 16'hBEEF);

        // Write 0x1234 to 0x3001
        BUS = 16'h3001; ld_mar0 = 1'b1;
        tick();
        ld_mar0 = 1'b0; BUS = 16'h1234; ld_mdr0 = 1'b1;
        tick();
        ld_mdr0 = 1'b0;
        start0 = 1'b1; we0 = 1'b1; mem_rdata = 16'hDEAD;
        q0.push_back('{mdr: 16'h1234, addr: 16'h3001, cyc: cyc + 3});
        tick();
        start0 = 1'b0; we0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check1("wr_ce", ce0, 1'b1);
            check1("wr_oe", oe0, 1'b0);
            check1("wr_we", wen0, 1'b1);
            check16("wr_addr", addr0, 16'h3001);
            check16("wr_wdata", wdata0, 16'h1234);
            tick();
        end
        check1("wr_done_we", wen0, 1'b0);
        tick();
        check16("wr_mdr_kept", mdr0, 16'h1234);

        // Reset in the first ACCESS cycle of a read
        start0 = 1'b1; we0 = 1'b0; mem_rdata = 16'hAAAA;
        tick();
        start0 = 1'b0;
        check1("abort_a1_ce", ce0, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check1("abort_ce", ce0, 1'b0);
        check1("abort_oe", oe0, 1'b0);
        check1("abort_busy", busy0, 1'b0);
        check16("abort_mdr", mdr0, 16'h0000);
        check16("abort_mar", mar0, 16'h0000);
        tick();
        tick();
        tick();
        check16("abort_mdr_later", mdr0, 16'h0000);

        // Simultaneous MAR load and start
        BUS = 16'h4000; ld_mar0 = 1'b1; start0 = 1'b1; we0 = 1'b0; mem_rdata = 16'hCAFE;
        q0.push_back('{mdr: 16'hCAFE, addr: 16'h4000, cyc: cyc + 3});
        tick();
        ld_mar0 = 1'b0; start0 = 1'b0; BUS = 16'h0BAD;
        for (int i = 0; i < 2; i++) begin
            check1("sim_ce", ce0, 1'b1);
            check16("sim_addr", addr0, 16'h4000);
            tick();
        end
        tick();

        // Same with WAIT_CYCLES=1: R two cycles after start
        BUS = 16'h4000; ld_mar1 = 1'b1; start1 = 1'b1; we1 = 1'b0; mem_rdata = 16'h1357;
        q1.push_back('{mdr: 16'h1357, addr: 16'h4000, cyc: cyc + 2});
        tick();
        ld_mar1 = 1'b0; start1 = 1'b0; BUS = 16'h0000;
        check1("w1_ce", ce1, 1'b1);
        check1("w1_oe", oe1, 1'b1);
        check16("w1_addr", addr1, 16'h4000);
        tick();
        check1("w1_done_ce", ce1, 1'b0);
        tick();
        tick();

        // Every expected R pulse must have been seen
        checki("dut0_pending", q0.size(), 0);
        checki("dut1_pending", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES SHALL be: WAIT_CYCLES, default 2, number of cycles the memory strobes are held per access; legal range 1..15.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  Clk  input  1  sole clock; all state updates on its rising edge
  Reset  input  1  synchronous, active-high reset
  BUS  input  16  CPU data bus, the output of the bus driver mux
  LD_MAR  input  1  load MAR from BUS
  LD_MDR  input  1  load MDR from BUS (CPU-side load)
  start  input  1  begin memory access, sampled only in IDLE
  we  input  1  access type, sampled with start: 1=write, 0=read
  mem_rdata  input  16  read data from memory
  MAR_Out  output  16  MAR contents
  MDR_Out  output  16  MDR contents; feeds the bus driver mux
  mem_addr  output  16  equals MAR_Out
  mem_wdata  output  16  equals MDR_Out
  mem_ce  output  1  chip enable, active-high
  mem_oe  output  1  output enable, active-high
  mem_we  output  1  write enable, active-high
  R  output  1  access-complete pulse, one cycle
  busy  output  1  high whenever state is not IDLE
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-005 IDLE with start=1 at an edge SHALL give: state<=ACCESS, we_lat<=we, cnt<=WAIT_CYCLES-1.
REQ-006 ACCESS with cnt!=0 at an edge SHALL decrement cnt; with cnt==0 it SHALL go to DONE, and if we_lat=0 SHALL load MDR<=mem_rdata at that same edge.
REQ-007 DONE SHALL go unconditionally to IDLE at the next edge.
REQ-008 In ACCESS the outputs SHALL be mem_ce=1, mem_oe=~we_lat, mem_we=we_lat; in IDLE and DONE all three SHALL be 0.
REQ-009 R SHALL be 1 only in DONE; latency SHALL be start sampled at edge k -> ACCESS for cycles k+1..k+WAIT_CYCLES -> R high in cycle k+WAIT_CYCLES+1.
REQ-010 MDR_Out SHALL hold the captured read data in the R cycle.
REQ-011 In IDLE only, LD_MAR SHALL load MAR<=BUS and LD_MDR SHALL load MDR<=BUS; both may load in the same cycle.
REQ-012 LD_MAR and LD_MDR SHALL be ignored while busy=1, so MAR/MDR stay stable during an access.
REQ-013 If start and LD_MAR/LD_MDR are all high at the same IDLE edge, the registers SHALL load and the access SHALL use the newly loaded values.
REQ-014 start SHALL be ignored in ACCESS and DONE; back-to-back accesses SHALL therefore have at least one IDLE cycle between them.
REQ-015 MAR and MDR SHALL be 16-bit with no arithmetic; the 4-bit cnt SHALL never wrap below 0.

Reset
REQ-016 Reset=1 at an edge SHALL force state=IDLE, cnt=0, we_lat=0, MAR=0x0000 and MDR=0x0000, overriding every other input.
REQ-017 After reset: mem_ce=mem_oe=mem_we=R=busy=0.
REQ-018 Reset during ACCESS SHALL abort the access with no MDR capture, and the strobes SHALL drop in the next cycle.

Structure
REQ-019 Package lc3_pkg SHALL hold the mem_state_t enum (IDLE, ACCESS, DONE) and the constant MEM_WAIT_DEFAULT=2.
REQ-020 Sub-module reg16 (16-bit register with synchronous reset and load enable) SHALL be instantiated twice, for MAR and MDR; the MDR input mux SHALL be local logic.

Verification
REQ-021 Reset then idle: Reset high 2 cycles -> MAR_Out=MDR_Out=0x0000, busy=R=mem_ce=0.
REQ-022 Read: BUS=0x3000 with LD_MAR, start=1, we=0, mem_rdata=0xBEEF -> mem_ce=mem_oe=1 for 2 cycles, then R=1 with MDR_Out=0xBEEF, 3 cycles after start.
REQ-023 Write: load MAR=0x3001 and MDR=0x1234, start, we=1 -> mem_we=1, mem_addr=0x3001 and mem_wdata=0x1234 for 2 cycles, R pulse, MDR unchanged.
REQ-024 Loads while busy: LD_MAR with BUS=0xFFFF during ACCESS -> MAR_Out stays 0x3000; start during DONE -> no new access.
REQ-025 Reset mid-access: Reset asserted in the first ACCESS cycle of a read -> no R pulse, MDR=0x0000, strobes low in the next cycle.
REQ-026 Simultaneous load and start: LD_MAR with BUS=0x4000 and start in the same IDLE cycle -> mem_addr=0x4000 throughout ACCESS; repeat with WAIT_CYCLES=1 -> R high 2 cycles after start.
